// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ariane_pkg (excerpt)
//  Brief    : SFENCE.VMA queue types: flush mode, queue entry, FSM state.
//  Revision : 1.0
// ============================================================================
package ariane_pkg;

    localparam int unsigned SFENCE_VLEN_MAX = 64;
    localparam int unsigned SFENCE_ASID_MAX = 16;

    typedef enum logic [1:0] {
        SFENCE_ALL        = 2'b00,
        SFENCE_ASID       = 2'b01,
        SFENCE_VADDR      = 2'b10,
        SFENCE_VADDR_ASID = 2'b11
    } sfence_mode_t;

    typedef struct packed {
        logic [SFENCE_VLEN_MAX-1:0] vaddr;
        logic [SFENCE_ASID_MAX-1:0] asid;
        sfence_mode_t               mode;
        logic                       committed;
    } sfence_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_SETTLE = 2'b10
    } sfence_state_t;

    // Bit 1 = "vaddr given" (rs1 != x0), bit 0 = "asid given" (rs2 != x0).
    function automatic sfence_mode_t sfence_mode(input logic rs1_zero, input logic rs2_zero);
        return sfence_mode_t'({~rs1_zero, ~rs2_zero});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfence_vma_queue.sv
`default_nettype none
// ============================================================================
//  Module   : sfence_vma_queue
//  Brief    : In-order SFENCE.VMA request queue with commit/flush tracking and
//             a handshaked TLB flush command port.
//  Revision : 1.0
// ============================================================================
module sfence_vma_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned VLEN       = 64,
    parameter int unsigned ASID_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [VLEN-1:0]              req_vaddr_i,
    input  logic [ASID_WIDTH-1:0]        req_asid_i,
    input  logic                         req_rs1_zero_i,
    input  logic                         req_rs2_zero_i,
    input  logic                         commit_i,
    output logic                         tlb_valid_o,
    input  logic                         tlb_ready_i,
    output sfence_mode_t                 tlb_mode_o,
    output logic [VLEN-1:0]              tlb_vaddr_o,
    output logic [ASID_WIDTH-1:0]        tlb_asid_o,
    output logic                         busy_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = $clog2(DEPTH+1);

    sfence_req_t        r_entries [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_ncommit;
    sfence_state_t      r_state;

    logic               w_push;
    logic               w_pop;
    logic               w_commit;
    logic [c_PTR_W-1:0] w_commit_idx;
    logic [c_PTR_W-1:0] w_head_nxt;
    logic [c_PTR_W-1:0] w_tail_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_CNT_W-1:0] w_ncommit_nxt;
    sfence_req_t        w_new_entry;

    assign req_ready_o = (r_count < c_CNT_W'(DEPTH));
    assign w_push      = req_valid_i & req_ready_o & ~flush_i;
    assign w_pop       = (r_state == ST_ISSUE) & tlb_ready_i;
    assign w_commit    = commit_i & (r_ncommit < r_count);
    // Commits retire in order, so committed entries always form a prefix from the head.
    assign w_commit_idx = r_head + c_PTR_W'(r_ncommit);

    assign busy_o  = (r_count != '0) | (r_state != ST_IDLE);
    assign count_o = r_count;

    always_comb begin
        w_new_entry.vaddr     = SFENCE_VLEN_MAX'(req_vaddr_i);
        w_new_entry.asid      = SFENCE_ASID_MAX'(req_asid_i);
        w_new_entry.mode      = sfence_mode(req_rs1_zero_i, req_rs2_zero_i);
        w_new_entry.committed = 1'b0;
    end

    // Commit is folded in before the flush trims the queue to the committed prefix.
    always_comb begin
        w_head_nxt    = r_head + c_PTR_W'(w_pop);
        w_ncommit_nxt = r_ncommit + c_CNT_W'(w_commit) - c_CNT_W'(w_pop);
        if (flush_i) begin
            w_count_nxt = w_ncommit_nxt;
            w_tail_nxt  = w_head_nxt + c_PTR_W'(w_ncommit_nxt);
        end else begin
            w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            w_tail_nxt  = r_tail + c_PTR_W'(w_push);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ncommit <= '0;
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= w_new_entry;
            end
            if (w_commit) begin
                r_entries[w_commit_idx].committed <= 1'b1;
            end
            if (w_pop) begin
                r_entries[r_head].committed <= 1'b0;
            end
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_count   <= w_count_nxt;
            r_ncommit <= w_ncommit_nxt;
        end
    end

    // Command outputs are registered and zeroed whenever no command is offered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            tlb_valid_o <= 1'b0;
            tlb_mode_o  <= SFENCE_ALL;
            tlb_vaddr_o <= '0;
            tlb_asid_o  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((r_count != '0) && r_entries[r_head].committed) begin
                        r_state     <= ST_ISSUE;
                        tlb_valid_o <= 1'b1;
                        tlb_mode_o  <= r_entries[r_head].mode;
                        tlb_vaddr_o <= VLEN'(r_entries[r_head].vaddr);
                        tlb_asid_o  <= ASID_WIDTH'(r_entries[r_head].asid);
                    end
                end
                ST_ISSUE: begin
                    if (tlb_ready_i) begin
                        r_state     <= ST_SETTLE;
                        tlb_valid_o <= 1'b0;
                        tlb_mode_o  <= SFENCE_ALL;
                        tlb_vaddr_o <= '0;
                        tlb_asid_o  <= '0;
                    end
                end
                ST_SETTLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    a_commit_has_entry: assert property (
        @(posedge clk_i) disable iff (rst_i) commit_i |-> (r_ncommit < r_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_sfence_vma_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfence_vma_queue
//  Brief    : Directed self-checking bench for sfence_vma_queue.
//  Revision : 1.0
// ============================================================================
module tb_sfence_vma_queue;
    import ariane_pkg::*;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned VLEN       = 64;
    localparam int unsigned ASID_WIDTH = 16;

    logic                  clk_i          = 1'b0;
    logic                  rst_i          = 1'b1;
    logic                  flush_i        = 1'b0;
    logic                  req_valid_i    = 1'b0;
    logic                  req_ready_o;
    logic [VLEN-1:0]       req_vaddr_i    = '0;
    logic [ASID_WIDTH-1:0] req_asid_i     = '0;
    logic                  req_rs1_zero_i = 1'b0;
    logic                  req_rs2_zero_i = 1'b0;
    logic                  commit_i       = 1'b0;
    logic                  tlb_valid_o;
    logic                  tlb_ready_i    = 1'b0;
    sfence_mode_t          tlb_mode_o;
    logic [VLEN-1:0]       tlb_vaddr_o;
    logic [ASID_WIDTH-1:0] tlb_asid_o;
    logic                  busy_o;
    logic [1:0]            count_o;

    int tests = 0;
    int fails = 0;
    int seen;

    always #5 clk_i = ~clk_i;

    sfence_vma_queue #(
        .DEPTH(DEPTH), .VLEN(VLEN), .ASID_WIDTH(ASID_WIDTH)
    ) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_vaddr_i(req_vaddr_i), .req_asid_i(req_asid_i),
        .req_rs1_zero_i(req_rs1_zero_i), .req_rs2_zero_i(req_rs2_zero_i),
        .commit_i(commit_i), .tlb_valid_o(tlb_valid_o), .tlb_ready_i(tlb_ready_i),
        .tlb_mode_o(tlb_mode_o), .tlb_vaddr_o(tlb_vaddr_o), .tlb_asid_o(tlb_asid_o),
        .busy_o(busy_o), .count_o(count_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive_push(input logic [63:0] va, input logic [15:0] asid,
                              input logic rs1z, input logic rs2z);
        req_valid_i    = 1'b1;
        req_vaddr_i    = va;
        req_asid_i     = asid;
        req_rs1_zero_i = rs1z;
        req_rs2_zero_i = rs2z;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!tlb_valid_o && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(tlb_valid_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_valid", 64'(tlb_valid_o), 64'd0);
        check("rst_mode",  64'(tlb_mode_o),  64'd0);
        check("rst_vaddr", tlb_vaddr_o,      64'd0);
        check("rst_asid",  64'(tlb_asid_o),  64'd0);
        check("rst_busy",  64'(busy_o),      64'd0);
        check("rst_count", 64'(count_o),     64'd0);
        rst_i = 1'b0;
        tick();

        // Single request, full path through ISSUE and SETTLE
        tlb_ready_i = 1'b1;
        drive_push(64'h8000_1000, 16'd5, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        check("t1_count", 64'(count_o), 64'd1);
        check("t1_busy", 64'(busy_o), 64'd1);
        check("t1_novalid", 64'(tlb_valid_o), 64'd0);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        check("t1_idle_after_commit", 64'(tlb_valid_o), 64'd0);
        tick();
        check("t1_valid", 64'(tlb_valid_o), 64'd1);
        check("t1_mode", 64'(tlb_mode_o), 64'd3);
        check("t1_vaddr", tlb_vaddr_o, 64'h8000_1000);
        check("t1_asid", 64'(tlb_asid_o), 64'd5);
        tick();
        check("t1_settle_valid", 64'(tlb_valid_o), 64'd0);
        check("t1_settle_vaddr", tlb_vaddr_o, 64'd0);
        check("t1_settle_count", 64'(count_o), 64'd0);
        check("t1_settle_busy", 64'(busy_o), 64'd1);
        tick();
        check("t1_done_busy", 64'(busy_o), 64'd0);

        // Fill to DEPTH without commit, third push refused, then flush empties it
        drive_push(64'h4000, 16'd2, 1'b1, 1'b1);
        tick();
        drive_push(64'h5000, 16'd3, 1'b1, 1'b0);
        tick();
        check("t2_count_full", 64'(count_o), 64'd2);
        check("t2_ready_low", 64'(req_ready_o), 64'd0);
        drive_push(64'h6000, 16'd4, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        check("t2_third_refused", 64'(count_o), 64'd2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t2_flush_count", 64'(count_o), 64'd0);
        check("t2_flush_busy", 64'(busy_o), 64'd0);

        // Committed A survives a flush, uncommitted B is dropped
        tlb_ready_i = 1'b0;
        drive_push(64'h1000, 16'd7, 1'b0, 1'b1);
        tick();
        req_valid_i = 1'b0;
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        drive_push(64'h2000, 16'd9, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        check("t3_count2", 64'(count_o), 64'd2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t3_count1", 64'(count_o), 64'd1);
        check("t3_valid", 64'(tlb_valid_o), 64'd1);
        check("t3_mode", 64'(tlb_mode_o), 64'd2);
        check("t3_vaddr", tlb_vaddr_o, 64'h1000);
        check("t3_asid", 64'(tlb_asid_o), 64'd7);
        tlb_ready_i = 1'b1;
        tick();
        check("t3_popped", 64'(count_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tlb_valid_o) seen++;
        end
        check("t3_b_never_issued", 64'(seen), 64'd0);
        check("t3_busy", 64'(busy_o), 64'd0);

        // Commit and flush together with two uncommitted entries
        tlb_ready_i = 1'b0;
        drive_push(64'h3000, 16'd1, 1'b1, 1'b0);
        tick();
        drive_push(64'h7000, 16'd4, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        check("t4_count2", 64'(count_o), 64'd2);
        commit_i = 1'b1;
        flush_i  = 1'b1;
        tick();
        commit_i = 1'b0;
        flush_i  = 1'b0;
        check("t4_count1", 64'(count_o), 64'd1);
        tick();
        check("t4_valid", 64'(tlb_valid_o), 64'd1);
        check("t4_mode", 64'(tlb_mode_o), 64'd1);
        check("t4_vaddr", tlb_vaddr_o, 64'h3000);
        check("t4_asid", 64'(tlb_asid_o), 64'd1);
        tlb_ready_i = 1'b1;
        tick();
        check("t4_popped", 64'(count_o), 64'd0);
        tick();
        tick();
        check("t4_busy", 64'(busy_o), 64'd0);

        // Stall in ISSUE for 5 cycles with a flush pulse in the middle
        tlb_ready_i = 1'b0;
        drive_push(64'hDEAD_B000, 16'h1234, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        wait_valid("t5_wait_valid");
        for (int i = 0; i < 5; i++) begin
            flush_i = (i == 2);
            tick();
            flush_i = 1'b0;
            check("t5_hold_valid", 64'(tlb_valid_o), 64'd1);
            check("t5_hold_vaddr", tlb_vaddr_o, 64'hDEAD_B000);
            check("t5_hold_asid", 64'(tlb_asid_o), 64'h1234);
        end
        check("t5_count", 64'(count_o), 64'd1);
        tlb_ready_i = 1'b1;
        tick();
        check("t5_released", 64'(tlb_valid_o), 64'd0);
        check("t5_count0", 64'(count_o), 64'd0);
        tick();

        // Back-to-back commands, no push bypass on pop, push+pop together, pointer wrap
        drive_push(64'hA000, 16'hA, 1'b0, 1'b0);
        tick();
        drive_push(64'hB000, 16'hB, 1'b0, 1'b0);
        commit_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        commit_i = 1'b0;
        check("t6_p_valid", 64'(tlb_valid_o), 64'd1);
        check("t6_p_vaddr", tlb_vaddr_o, 64'hA000);
        check("t6_full_ready", 64'(req_ready_o), 64'd0);
        drive_push(64'hC000, 16'hC, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        check("t6_no_bypass_count", 64'(count_o), 64'd1);
        check("t6_gap1", 64'(tlb_valid_o), 64'd0);
        tick();
        check("t6_gap2", 64'(tlb_valid_o), 64'd0);
        tick();
        check("t6_q_valid", 64'(tlb_valid_o), 64'd1);
        check("t6_q_vaddr", tlb_vaddr_o, 64'hB000);
        drive_push(64'hC000, 16'hC, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        check("t6_pushpop_count", 64'(count_o), 64'd1);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        tick();
        check("t6_r_valid", 64'(tlb_valid_o), 64'd1);
        check("t6_r_vaddr", tlb_vaddr_o, 64'hC000);
        check("t6_r_asid", 64'(tlb_asid_o), 64'hC);
        tick();
        tick();
        check("t6_busy", 64'(busy_o), 64'd0);
        check("t6_count", 64'(count_o), 64'd0);

        // Asynchronous reset in the middle of ISSUE
        tlb_ready_i = 1'b0;
        drive_push(64'hF000, 16'hF, 1'b1, 1'b1);
        tick();
        req_valid_i = 1'b0;
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        wait_valid("t7_wait_valid");
        #2;
        rst_i = 1'b1;
        #1;
        check("t7_async_valid", 64'(tlb_valid_o), 64'd0);
        check("t7_async_count", 64'(count_o), 64'd0);
        check("t7_async_ready", 64'(req_ready_o), 64'd1);
        check("t7_async_vaddr", tlb_vaddr_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        check("t7_post_valid", 64'(tlb_valid_o), 64'd0);
        check("t7_post_busy", 64'(busy_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sfence_vma_queue.md
SFENCE_VMA_QUEUE -- requirements
Module: sfence_vma_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of queued SFENCE.VMA requests (power of two, >=2).
REQ-002 SHALL have parameter VLEN, default 64, virtual address width.
REQ-003 SHALL have parameter ASID_WIDTH, default 16, ASID width.
REQ-004 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush_i  in  1  pipeline flush; drops uncommitted entries.
REQ-007 SHALL have port req_valid_i  in  1  EX stage presents an SFENCE.VMA.
REQ-008 SHALL have port req_ready_o  out  1  queue can accept a request.
REQ-009 SHALL have port req_vaddr_i  in  VLEN  forwarded rs1 value.
REQ-010 SHALL have port req_asid_i  in  ASID_WIDTH  forwarded rs2[ASID_WIDTH-1:0].
REQ-011 SHALL have port req_rs1_zero_i / req_rs2_zero_i  in  1 each  rs1 / rs2 register index is x0.
REQ-012 SHALL have port commit_i  in  1  commit stage retires the oldest uncommitted SFENCE.VMA.
REQ-013 SHALL have port tlb_valid_o  out  1  flush command to TLBs valid.
REQ-014 SHALL have port tlb_ready_i  in  1  TLBs accept the command.
REQ-015 SHALL have port tlb_mode_o  out  2  sfence_mode_t: 00 ALL, 01 ASID, 10 VADDR, 11 VADDR_ASID.
REQ-016 SHALL have port tlb_vaddr_o / tlb_asid_o  out  VLEN / ASID_WIDTH  command operands.
REQ-017 SHALL have port busy_o  out  1  entries queued or FSM not IDLE.
REQ-018 SHALL have port count_o  out  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-019 SHALL set req_ready_o = (count < DEPTH), with no same-cycle bypass from a pop.
REQ-020 SHALL capture vaddr, asid and mode at the tail on req_valid_i & req_ready_o, with committed=0.
REQ-021 SHALL encode mode as: rs1_zero & rs2_zero -> ALL; rs1_zero only -> ASID; rs2_zero only -> VADDR; neither -> VADDR_ASID.
REQ-022 SHALL, on commit_i, mark the oldest uncommitted entry committed; commit_i with no uncommitted entry is ignored and flagged by an assertion.
REQ-023 SHALL, on flush_i, invalidate all uncommitted entries; committed entries survive, in order.
REQ-024 SHALL, when commit_i and flush_i coincide, apply the commit first, then the flush.
REQ-025 SHALL discard a push that coincides with flush_i.
REQ-026 SHALL run the FSM IDLE -> ISSUE when the head is valid and committed.
REQ-027 SHALL, in ISSUE, hold tlb_valid_o=1 and the operands stable until tlb_ready_i; on that handshake, pop the head and go to SETTLE.
REQ-028 SHALL hold tlb_valid_o=0 for exactly one cycle in SETTLE, then go to IDLE; back-to-back commands are therefore spaced at least 2 cycles apart.
REQ-029 SHALL NOT abort ISSUE or SETTLE on flush_i, since the head is committed.
REQ-030 SHALL handle a push and a pop in the same cycle with count unchanged, and wrap head/tail pointers modulo DEPTH.
REQ-031 SHALL drive tlb_vaddr_o/tlb_asid_o to zero whenever tlb_valid_o=0 (data silencing).

Reset
REQ-032 SHALL, on rst_i asserted asynchronously (including mid-handshake), clear all entries, pointers and count, and return the FSM to IDLE.
REQ-033 SHALL hold outputs in reset at: req_ready_o=1, tlb_valid_o=0, tlb_mode_o=00, tlb_vaddr_o=0, tlb_asid_o=0, busy_o=0, count_o=0.
REQ-034 SHALL leave reset with a synchronous deassertion edge relative to clk_i.

Structure
REQ-035 SHALL place sfence_mode_t and the sfence_req_t struct {vaddr, asid, mode, committed} in ariane_pkg.
REQ-036 SHALL be instantiated in ex_stage in place of the single-entry vaddr/asid capture registers; the outputs feed the LSU TLB flush inputs.
REQ-037 SHALL be a single module; entry storage is inline flops; no sub-module.

Verification
REQ-038 SHALL cover: push (vaddr=0x8000_1000, asid=5, neither zero), commit, tlb_ready_i=1 -> tlb_valid_o high for 1 cycle, mode=11, operands match, then SETTLE, then busy_o=0.
REQ-039 SHALL cover: push DEPTH=2 requests without commit -> req_ready_o=0, count_o=2; a third req_valid_i is not accepted.
REQ-040 SHALL cover: push A, commit A, push B, flush_i -> only A is issued (mode per flags); count_o=0 afterwards; B is never seen.
REQ-041 SHALL cover: commit_i and flush_i in the same cycle with 2 uncommitted entries -> the first is issued, the second is dropped.
REQ-042 SHALL cover: tlb_ready_i held low 5 cycles in ISSUE -> tlb_valid_o and operands stable for all 5 cycles; flush_i pulsed meanwhile has no effect.
REQ-043 SHALL cover: rst_i asserted in ISSUE -> tlb_valid_o=0 and count_o=0 asynchronously, before the next clock edge.
